// File: rtl/pipe_pkg.sv
// Shared definitions for the handshaked pipeline-stage registers of the five-stage core.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam int ID_EX_DATA_W = 160;
  localparam int ID_EX_CTRL_W = 16;

  // Number of entries held in each state; the encoding equals the entry count.
  function automatic logic [1:0] occ_of(state_e st);
    return logic'(st == ST_TWO) ? 2'd2 : (st == ST_ONE) ? 2'd1 : 2'd0;
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One payload slot of a pipeline stage: datapath and control fields with load and control clear.
module pipe_entry_reg #(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              clr_ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  // Clearing touches only control, so the datapath keeps its last value across a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      ctrl_q <= '0;
    end else if (load_i) begin
      data_q <= data_i;
      ctrl_q <= ctrl_i;
    end else if (clr_ctrl_i) begin
      ctrl_q <= '0;
    end
  end

  assign data_o = data_q;
  assign ctrl_o = ctrl_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline-stage register with optional 2-entry skid buffer, flush and bubble clearing.
//   state    | meaning
//   ST_EMPTY | nothing held, out_valid=0, main control cleared
//   ST_ONE   | main entry valid and driving the outputs
//   ST_TWO   | main and skid valid, upstream stalled
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W  = ID_EX_DATA_W,
  parameter int CTRL_W  = ID_EX_CTRL_W,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_e state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic in_fire, out_fire;
  logic main_load, main_clr, main_from_skid;
  logic skid_load, skid_clr;
  logic [DATA_W-1:0] skid_data, main_in_data;
  logic [CTRL_W-1:0] skid_ctrl, main_in_ctrl;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign occupancy = occ_of(state_q);

  generate
    if (SKID_EN != 0) begin : g_ready_reg
      // Depends on state only, which breaks the out_ready -> in_ready timing path.
      assign in_ready = (state_q != ST_TWO);
    end else begin : g_ready_comb
      assign in_ready = (state_q == ST_EMPTY) | out_ready;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_load = 1'b1;
          state_d   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (in_fire && (SKID_EN != 0)) begin
          skid_load = 1'b1;
          state_d   = ST_TWO;
        end else if (out_fire) begin
          main_clr = 1'b1;
          state_d  = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_fire) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ST_ONE;
        end
      end
      default: begin
        main_clr = 1'b1;
        state_d  = ST_EMPTY;
      end
    endcase
    // Flush overrides everything, including an accept in the same cycle.
    if (flush) begin
      state_d        = ST_EMPTY;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      main_clr       = 1'b1;
      skid_clr       = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt    = stall_q;
  assign main_in_data = main_from_skid ? skid_data : in_data;
  assign main_in_ctrl = main_from_skid ? skid_ctrl : in_ctrl;

  pipe_entry_reg #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk        (clk),
    .reset      (reset),
    .load_i     (main_load),
    .clr_ctrl_i (main_clr),
    .data_i     (main_in_data),
    .ctrl_i     (main_in_ctrl),
    .data_o     (out_data),
    .ctrl_o     (out_ctrl)
  );

  generate
    if (SKID_EN != 0) begin : g_skid
      pipe_entry_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
      ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .load_i     (skid_load),
        .clr_ctrl_i (skid_clr),
        .data_i     (in_data),
        .ctrl_i     (in_ctrl),
        .data_o     (skid_data),
        .ctrl_o     (skid_ctrl)
      );
    end else begin : g_no_skid
      assign skid_data = '0;
      assign skid_ctrl = '0;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: skid and no-skid instances compared each cycle against a FIFO model.
module tb_pipe_stage_skid;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int NW = 4;
  localparam int SAT = 15;

  logic clk = 1'b0;
  logic reset, in_valid, flush, out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic          r0, v0, r1, v1;
  logic [DW-1:0] d0, d1;
  logic [CW-1:0] c0, c1;
  logic [1:0]    o0, o1;
  logic [NW-1:0] s0, s1;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model state per instance: index 1 = skid instance, index 0 = single-entry instance.
  int            cnt    [2];
  logic [DW-1:0] md     [2][2];
  logic [CW-1:0] mc     [2][2];
  logic [DW-1:0] last_d [2];
  int            stl    [2];

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1), .CNT_W(NW)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r1), .in_data(in_data),
    .in_ctrl(in_ctrl), .flush(flush), .out_valid(v1), .out_ready(out_ready),
    .out_data(d1), .out_ctrl(c1), .occupancy(o1), .stall_cnt(s1));

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(0), .CNT_W(NW)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r0), .in_data(in_data),
    .in_ctrl(in_ctrl), .flush(flush), .out_valid(v0), .out_ready(out_ready),
    .out_data(d0), .out_ctrl(c0), .occupancy(o0), .stall_cnt(s0));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit mrdy(int m);
    if (m == 1) return cnt[1] < 2;
    return (cnt[0] == 0) || out_ready;
  endfunction

  task automatic reset_model();
    for (int m = 0; m < 2; m++) begin
      cnt[m] = 0; last_d[m] = '0; stl[m] = 0;
      md[m][0] = '0; md[m][1] = '0; mc[m][0] = '0; mc[m][1] = '0;
    end
  endtask

  task automatic update_model(input int m);
    bit fi, fo;
    fi = in_valid && mrdy(m);
    fo = (cnt[m] > 0) && out_ready;
    if ((cnt[m] > 0) && !out_ready && (stl[m] < SAT)) stl[m]++;
    if (flush) begin
      cnt[m] = 0;
    end else begin
      if (fo) begin
        md[m][0] = md[m][1]; mc[m][0] = mc[m][1]; cnt[m]--;
      end
      if (fi) begin
        md[m][cnt[m]] = in_data; mc[m][cnt[m]] = in_ctrl; cnt[m]++;
      end
    end
    if (cnt[m] > 0) last_d[m] = md[m][0];
  endtask

  task automatic compare_one(input int m, input logic rdy, input logic vld,
                             input logic [DW-1:0] dat, input logic [CW-1:0] ctl,
                             input logic [1:0] occ, input logic [NW-1:0] stc);
    string p;
    p = (m == 1) ? "skid" : "noskid";
    chk({p, ".in_ready"},  32'(rdy), 32'(mrdy(m)));
    chk({p, ".out_valid"}, 32'(vld), 32'(cnt[m] > 0));
    chk({p, ".out_data"},  32'(dat), 32'(last_d[m]));
    chk({p, ".out_ctrl"},  32'(ctl), (cnt[m] > 0) ? 32'(mc[m][0]) : 32'd0);
    chk({p, ".occupancy"}, 32'(occ), 32'(cnt[m]));
    chk({p, ".stall_cnt"}, 32'(stc), 32'(stl[m]));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      compare_one(1, r1, v1, d1, c1, o1, s1);
      compare_one(0, r0, v0, d0, c0, o0, s0);
    end
  end

  task automatic step();
    @(posedge clk);
    if (reset) reset_model();
    else begin
      update_model(0);
      update_model(1);
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic fl);
    in_valid = v; in_data = d; in_ctrl = c; out_ready = ordy; flush = fl;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, '0, '0, 0, 0);
    reset_model();
    chk_en = 1'b1;
    #2;
    chk("reset.out_valid", 32'(v1), 0);
    chk("reset.in_ready_skid", 32'(r1), 1);
    chk("reset.in_ready_noskid", 32'(r0), 1);
    chk("reset.stall_cnt", 32'(s1), 0);
    #10 reset = 1'b0;
    step();

    // Streaming at full rate
    for (int i = 1; i <= 4; i++) begin
      drive(1, 16'(i), 16'(i * 3), 1, 0);
      step();
      chk("stream.out_data", 32'(d1), 32'(i));
      chk("stream.occupancy", 32'(o1), 1);
    end
    drive(0, '0, '0, 1, 0);
    step();
    chk("stream.stall_cnt", 32'(s1), 0);

    // Backpressure into the skid slot
    drive(1, 16'h00A, 16'h1, 1, 0); step();
    drive(1, 16'h00B, 16'h2, 0, 0); #1;
    chk("noskid.in_ready_comb_low", 32'(r0), 0);
    step();
    drive(1, 16'h00C, 16'h3, 0, 0); step();
    step();
    chk("bp.stall_cnt", 32'(s1), 3);
    chk("bp.occupancy", 32'(o1), 2);
    chk("bp.in_ready", 32'(r1), 0);
    chk("bp.head", 32'(d1), 32'h00A);
    drive(1, 16'h00C, 16'h3, 1, 0); #1;
    chk("noskid.in_ready_comb_high", 32'(r0), 1);
    step();
    chk("bp.second", 32'(d1), 32'h00B);
    step();
    chk("bp.third", 32'(d1), 32'h00C);
    drive(0, '0, '0, 1, 0); step();
    chk("bp.drained", 32'(v1), 0);

    // Flush from the full state with an incoming entry
    drive(1, 16'h00D, 16'hD, 0, 0); step();
    drive(1, 16'h00E, 16'hE, 0, 0); step();
    drive(1, 16'h00F, 16'hF, 0, 1); step();
    chk("flush.out_valid", 32'(v1), 0);
    chk("flush.out_ctrl", 32'(c1), 0);
    chk("flush.occupancy", 32'(o1), 0);
    chk("flush.data_held", 32'(d1), 32'h00D);
    drive(0, '0, '0, 1, 0); step();
    chk("flush.no_ghost", 32'(v1), 0);

    // Bubble after full-ones control
    drive(1, 16'h055, 16'hFFFF, 0, 0); step();
    drive(1, 16'h066, 16'hFFFF, 0, 0); step();
    drive(0, '0, '0, 1, 0); step();
    chk("bubble.ctrl_live", 32'(c1), 32'hFFFF);
    step();
    chk("bubble.out_valid", 32'(v1), 0);
    chk("bubble.ctrl_zero", 32'(c1), 0);
    chk("bubble.data_held", 32'(d1), 32'h066);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      step();
    end
    drive(0, '0, '0, 1, 0);
    repeat (3) step();

    // Saturate the stall counter in the full state, then reset between edges
    drive(1, 16'h077, 16'h1234, 0, 0); step();
    drive(1, 16'h088, 16'h5678, 0, 0); step();
    repeat (16) step();
    chk("sat.stall_cnt", 32'(s1), SAT);
    chk("sat.occupancy", 32'(o1), 2);
    #1;
    reset = 1'b1;
    reset_model();
    #1;
    chk("areset.out_valid", 32'(v1), 0);
    chk("areset.out_data", 32'(d1), 0);
    chk("areset.out_ctrl", 32'(c1), 0);
    chk("areset.occupancy", 32'(o1), 0);
    chk("areset.stall_cnt", 32'(s1), 0);
    chk("areset.in_ready", 32'(r1), 1);
    step();
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 16'(100 + i), 16'(i), 1, 0);
      step();
    end
    drive(0, '0, '0, 1, 0);
    repeat (2) step();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
